ysyx_23060203_axi_sram: RTL and testbench

AXI4 memory responder for the simulation and FPGA SoC: the target end of the LSU data port and the IFU fetch port. It accepts read and write bursts on independent channels and serves them from an internal word array. Read data returns after a programmable access latency; writes complete with a B response after the last beat. Its handshake timing is deliberately controllable, so pipeline stall paths in the core can be exercised.

---
 rtl/ysyx_23060203_axi_sram.sv | 236 +++++++++++++++++++++++
 tb/tb_ysyx_23060203_axi_sram.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_axi_sram.sv
// AXI4 SRAM responder with independent read/write FSMs and programmable latency.
// Define YSYX_23060203_SRAM_RAND_DELAY_EN to add LFSR-driven ready stalls.
module ysyx_23060203_axi_sram #(
   parameter int ADDR_W = 16,
   parameter int RD_LAT = 2,
   parameter int WR_LAT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   input  logic [3:0]  arid,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic [3:0]  rid,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awid,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        wvalid,
   output logic        wready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp,
   output logic [3:0]  bid
);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wstate_t;

   logic [31:0] mem_q [2**ADDR_W];

   rstate_t             rstate_q, rstate_d;
   logic [3:0]          rid_q, rid_d;
   logic [7:0]          rlen_q, rlen_d, rcnt_q, rcnt_d, rbeat_q, rbeat_d;
   logic [1:0]          rburst_q, rburst_d;
   logic [ADDR_W-1:0]   ridx_q, ridx_d, ridx_nx;
   logic                rerr_q, rerr_d, rlast_q, rlast_d;
   logic [31:0]         rdata_q, rdata_d;

   wstate_t             wstate_q, wstate_d;
   logic [3:0]          wid_q, wid_d;
   logic [7:0]          wlen_q, wlen_d, wcnt_q, wcnt_d, wbeat_q, wbeat_d;
   logic [1:0]          wburst_q, wburst_d;
   logic [ADDR_W-1:0]   widx_q, widx_d, widx_nx;
   logic                werr_q, werr_d, wbad_q, wbad_d;

   logic                rst_done_q;
   logic                ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic                unused_addr;

   assign unused_addr = ^{araddr[31:ADDR_W+2], araddr[1:0], awaddr[31:ADDR_W+2], awaddr[1:0]};

   // Ready outputs stay low until the first edge with reset deasserted.
`ifdef YSYX_23060203_SRAM_RAND_DELAY_EN
   logic [15:0] lfsr_q;
   always_ff @(posedge clock) begin
      if (reset) lfsr_q <= 16'hACE1;
      else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end
   assign arready = (rstate_q == R_IDLE) && rst_done_q && !lfsr_q[0];
   assign awready = (wstate_q == W_IDLE) && rst_done_q && !lfsr_q[0];
   assign wready  = (wstate_q == W_DATA) && !lfsr_q[1];
`else
   assign arready = (rstate_q == R_IDLE) && rst_done_q;
   assign awready = (wstate_q == W_IDLE) && rst_done_q;
   assign wready  = (wstate_q == W_DATA);
`endif

   assign rvalid = (rstate_q == R_DATA);
   assign bvalid = (wstate_q == W_RESP);
   assign rdata  = rdata_q;
   assign rlast  = rlast_q & rvalid;
   assign rresp  = rerr_q ? 2'b10 : 2'b00;
   assign rid    = rid_q;
   assign bresp  = (werr_q | wbad_q) ? 2'b10 : 2'b00;
   assign bid    = wid_q;

   assign ar_hs = arvalid & arready;
   assign r_hs  = rvalid & rready;
   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;
   assign b_hs  = bvalid & bready;

   always_comb begin
      rstate_d = rstate_q;
      rid_d    = rid_q;
      rlen_d   = rlen_q;
      rcnt_d   = rcnt_q;
      rbeat_d  = rbeat_q;
      rburst_d = rburst_q;
      ridx_d   = ridx_q;
      rerr_d   = rerr_q;
      rlast_d  = rlast_q;
      rdata_d  = rdata_q;
      ridx_nx  = (rburst_q == 2'b01) ? ridx_q + ADDR_W'(1) : ridx_q;
      unique case (rstate_q)
         R_IDLE: if (ar_hs) begin
            rstate_d = R_WAIT;
            rid_d    = arid;
            rlen_d   = arlen;
            rburst_d = arburst;
            ridx_d   = araddr[ADDR_W+1:2];
            rerr_d   = arburst[1] | (arsize > 3'd2);
            rcnt_d   = 8'(RD_LAT - 1);
         end
         R_WAIT: if (rcnt_q == 8'd0) begin
            rstate_d = R_DATA;
            rbeat_d  = '0;
            rdata_d  = rerr_q ? '0 : mem_q[ridx_q];
            rlast_d  = (rlen_q == 8'd0);
         end else begin
            rcnt_d = rcnt_q - 8'd1;
         end
         R_DATA: if (r_hs) begin
            if (rlast_q) begin
               rstate_d = R_IDLE;
            end else begin
               rbeat_d = rbeat_q + 8'd1;
               ridx_d  = ridx_nx;
               rdata_d = rerr_q ? '0 : mem_q[ridx_nx];
               rlast_d = (rbeat_d == rlen_q);
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      wstate_d = wstate_q;
      wid_d    = wid_q;
      wlen_d   = wlen_q;
      wcnt_d   = wcnt_q;
      wbeat_d  = wbeat_q;
      wburst_d = wburst_q;
      widx_d   = widx_q;
      werr_d   = werr_q;
      wbad_d   = wbad_q;
      widx_nx  = (wburst_q == 2'b01) ? widx_q + ADDR_W'(1) : widx_q;
      unique case (wstate_q)
         W_IDLE: if (aw_hs) begin
            wstate_d = W_DATA;
            wid_d    = awid;
            wlen_d   = awlen;
            wburst_d = awburst;
            widx_d   = awaddr[ADDR_W+1:2];
            werr_d   = awburst[1] | (awsize > 3'd2);
            wbad_d   = 1'b0;
            wbeat_d  = '0;
         end
         // The beat count ends the burst; wlast only flags a protocol error.
         W_DATA: if (w_hs) begin
            if (wlast != (wbeat_q == wlen_q)) wbad_d = 1'b1;
            if (wbeat_q == wlen_q) begin
               wstate_d = W_WAIT;
               wcnt_d   = 8'(WR_LAT - 1);
            end else begin
               wbeat_d = wbeat_q + 8'd1;
               widx_d  = widx_nx;
            end
         end
         W_WAIT: if (wcnt_q == 8'd0) wstate_d = W_RESP;
                 else                wcnt_d   = wcnt_q - 8'd1;
         W_RESP: if (b_hs) wstate_d = W_IDLE;
         default: wstate_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rst_done_q <= 1'b0;
         rstate_q   <= R_IDLE;
         rid_q      <= '0;
         rlen_q     <= '0;
         rcnt_q     <= '0;
         rbeat_q    <= '0;
         rburst_q   <= '0;
         ridx_q     <= '0;
         rerr_q     <= 1'b0;
         rlast_q    <= 1'b0;
         rdata_q    <= '0;
         wstate_q   <= W_IDLE;
         wid_q      <= '0;
         wlen_q     <= '0;
         wcnt_q     <= '0;
         wbeat_q    <= '0;
         wburst_q   <= '0;
         widx_q     <= '0;
         werr_q     <= 1'b0;
         wbad_q     <= 1'b0;
      end else begin
         rst_done_q <= 1'b1;
         rstate_q   <= rstate_d;
         rid_q      <= rid_d;
         rlen_q     <= rlen_d;
         rcnt_q     <= rcnt_d;
         rbeat_q    <= rbeat_d;
         rburst_q   <= rburst_d;
         ridx_q     <= ridx_d;
         rerr_q     <= rerr_d;
         rlast_q    <= rlast_d;
         rdata_q    <= rdata_d;
         wstate_q   <= wstate_d;
         wid_q      <= wid_d;
         wlen_q     <= wlen_d;
         wcnt_q     <= wcnt_d;
         wbeat_q    <= wbeat_d;
         wburst_q   <= wburst_d;
         widx_q     <= widx_d;
         werr_q     <= werr_d;
         wbad_q     <= wbad_d;
      end
   end

   always_ff @(posedge clock) begin
      if (w_hs && !werr_q && !reset) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb[b]) mem_q[widx_q][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060203_axi_sram.sv
// Directed self-checking bench for ysyx_23060203_axi_sram with default parameters.
module tb_ysyx_23060203_axi_sram;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        arvalid = 1'b0, arready;
   logic [31:0] araddr = '0;
   logic [3:0]  arid = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = '0;
   logic [1:0]  arburst = '0;
   logic        rvalid, rready = 1'b0;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;
   logic        awvalid = 1'b0, awready;
   logic [31:0] awaddr = '0;
   logic [3:0]  awid = '0;
   logic [7:0]  awlen = '0;
   logic [2:0]  awsize = '0;
   logic [1:0]  awburst = '0;
   logic        wvalid = 1'b0, wready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wlast = 1'b0;
   logic        bvalid, bready = 1'b0;
   logic [1:0]  bresp;
   logic [3:0]  bid;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   ysyx_23060203_axi_sram #(.ADDR_W(16), .RD_LAT(2), .WR_LAT(1)) dut (
      .clock(clock), .reset(reset),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rid(rid),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
   );

   // All tasks start and end 1 time unit after a rising edge.
   task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
      logic hs = 1'b0;
      araddr = a; arid = id; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
      for (int n = 0; n < 20 && !hs; n++) begin
         @(negedge clock); hs = arready;
         @(posedge clock); #1;
      end
      arvalid = 1'b0;
      total++;
      if (!hs) begin bad++; $display("FAIL ar_handshake got=0 want=1"); end
   endtask

   task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
      logic hs = 1'b0;
      awaddr = a; awid = id; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
      for (int n = 0; n < 20 && !hs; n++) begin
         @(negedge clock); hs = awready;
         @(posedge clock); #1;
      end
      awvalid = 1'b0;
      total++;
      if (!hs) begin bad++; $display("FAIL aw_handshake got=0 want=1"); end
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
      logic hs = 1'b0;
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      for (int n = 0; n < 20 && !hs; n++) begin
         @(negedge clock); hs = wready;
         @(posedge clock); #1;
      end
      wvalid = 1'b0;
      total++;
      if (!hs) begin bad++; $display("FAIL w_handshake got=0 want=1"); end
   endtask

   task automatic b_get(output logic [1:0] resp, output logic [3:0] id);
      resp = 2'bxx; id = 4'hx;
      for (int n = 0; n < 20 && !bvalid; n++) begin @(posedge clock); #1; end
      total++;
      if (!bvalid) begin
         bad++; $display("FAIL b_timeout got=0 want=1");
      end else begin
         resp = bresp; id = bid; bready = 1'b1;
         @(posedge clock); #1; bready = 1'b0;
      end
   endtask

   task automatic r_get(output logic [31:0] d, output logic [1:0] resp, output logic l,
                        output logic [3:0] id);
      d = 'x; resp = 2'bxx; l = 1'bx; id = 4'hx;
      for (int n = 0; n < 20 && !rvalid; n++) begin @(posedge clock); #1; end
      total++;
      if (!rvalid) begin
         bad++; $display("FAIL r_timeout got=0 want=1");
      end else begin
         d = rdata; resp = rresp; l = rlast; id = rid; rready = 1'b1;
         @(posedge clock); #1; rready = 1'b0;
      end
   endtask

   task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [1:0] r; logic [3:0] i;
      aw_send(a, 4'h0, 8'd0, 2'b01, 3'd2);
      w_send(d, s, 1'b1);
      b_get(r, i);
   endtask

   task automatic read_word(input logic [31:0] a, output logic [31:0] d);
      logic [1:0] r; logic l; logic [3:0] i;
      ar_send(a, 4'h0, 8'd0, 2'b01, 3'd2);
      r_get(d, r, l, i);
   endtask

   task automatic test_reset;
      total++;
      if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b want=000000", {arready, awready, wready, rvalid, bvalid, rlast});
      end
      total++;
      if ({rdata, rresp, bresp, rid, bid} !== 44'h0) begin
         bad++; $display("FAIL reset_data got=%h want=0", {rdata, rresp, bresp, rid, bid});
      end
      reset = 1'b0;
      total++;
      if (arready !== 1'b0) begin bad++; $display("FAIL arready_before_edge got=%b want=0", arready); end
      @(posedge clock); #1;
      total++;
      if ({arready, awready} !== 2'b11) begin bad++; $display("FAIL ready_after_reset got=%b want=11", {arready, awready}); end
      wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
      @(posedge clock); #1;
      total++;
      if (wready !== 1'b0) begin bad++; $display("FAIL w_before_aw got=%b want=0", wready); end
      wvalid = 1'b0;
   endtask

   task automatic test_single_read;
      int lat = 0;
      write_word(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
      ar_send(32'h8000_0010, 4'hA, 8'd0, 2'b01, 3'd2);
      while (!rvalid && lat < 10) begin @(posedge clock); #1; lat++; end
      total++;
      if (lat != 2) begin bad++; $display("FAIL rd_latency got=%0d want=2", lat); end
      total++;
      if ({rdata, rlast, rresp, rid} !== {32'hDEAD_BEEF, 1'b1, 2'b00, 4'hA}) begin
         bad++; $display("FAIL single_read got=%h/%b/%b/%h want=deadbeef/1/00/a", rdata, rlast, rresp, rid);
      end
      rready = 1'b1; @(posedge clock); #1; rready = 1'b0;
      total++;
      if ({rvalid, arready} !== 2'b01) begin bad++; $display("FAIL read_done got=%b want=01", {rvalid, arready}); end
   endtask

   task automatic test_incr_backpressure;
      logic [1:0] r; logic [3:0] i;
      int cur = 0;
      aw_send(32'h8000_0000, 4'h3, 8'd3, 2'b01, 3'd2);
      for (int k = 0; k < 4; k++) w_send(32'(k + 1), 4'hF, k == 3);
      b_get(r, i);
      total++;
      if ({r, i} !== {2'b00, 4'h3}) begin bad++; $display("FAIL burst_write_b got=%b/%h want=00/3", r, i); end
      ar_send(32'h8000_0000, 4'h5, 8'd3, 2'b01, 3'd2);
      for (int n = 0; n < 10 && !rvalid; n++) begin @(posedge clock); #1; end
      for (int k = 0; k < 20 && cur < 4; k++) begin
         total++;
         if ({rvalid, rdata, rlast, rid, arready} !== {1'b1, 32'(cur + 1), cur == 3, 4'h5, 1'b0}) begin
            bad++; $display("FAIL incr_beat%0d got=%b/%h/%b/%h/%b want=1/%h/%b/5/0",
                            cur, rvalid, rdata, rlast, rid, arready, cur + 1, cur == 3);
         end
         rready = (k % 2 == 0);
         @(posedge clock); #1;
         if (rready) cur++;
         rready = 1'b0;
      end
      total++;
      if (cur != 4 || rvalid !== 1'b0) begin bad++; $display("FAIL incr_end got=%0d/%b want=4/0", cur, rvalid); end
   endtask

   task automatic test_strobe_write;
      int lat = 0;
      logic [31:0] d;
      write_word(32'h8000_0100, 32'h1122_3344, 4'hF);
      aw_send(32'h8000_0100, 4'h6, 8'd0, 2'b01, 3'd2);
      w_send(32'hAABB_CCDD, 4'b0101, 1'b1);
      while (!bvalid && lat < 10) begin @(posedge clock); #1; lat++; end
      total++;
      if (lat != 1) begin bad++; $display("FAIL wr_latency got=%0d want=1", lat); end
      total++;
      if ({bresp, bid} !== {2'b00, 4'h6}) begin bad++; $display("FAIL strobe_b got=%b/%h want=00/6", bresp, bid); end
      bready = 1'b1; @(posedge clock); #1; bready = 1'b0;
      read_word(32'h8000_0100, d);
      total++;
      if (d !== 32'h11BB_33DD) begin bad++; $display("FAIL strobe_data got=%h want=11bb33dd", d); end
   endtask

   task automatic test_wlast_mismatch;
      logic [1:0] r; logic [3:0] i; logic [31:0] d0, d1;
      aw_send(32'h8000_0200, 4'h7, 8'd1, 2'b01, 3'd2);
      w_send(32'h0000_AAAA, 4'hF, 1'b1);
      w_send(32'h0000_BBBB, 4'hF, 1'b1);
      b_get(r, i);
      total++;
      if ({r, i} !== {2'b10, 4'h7}) begin bad++; $display("FAIL wlast_b got=%b/%h want=10/7", r, i); end
      read_word(32'h8000_0200, d0);
      read_word(32'h8000_0204, d1);
      total++;
      if ({d0, d1} !== {32'h0000_AAAA, 32'h0000_BBBB}) begin
         bad++; $display("FAIL wlast_data got=%h/%h want=0000aaaa/0000bbbb", d0, d1);
      end
   endtask

   task automatic test_error_bursts;
      logic [1:0] r; logic [3:0] i; logic [31:0] d; logic l;
      write_word(32'h8000_0300, 32'h1234_5678, 4'hF);
      aw_send(32'h8000_0300, 4'h1, 8'd0, 2'b01, 3'd3);
      w_send(32'hFFFF_FFFF, 4'hF, 1'b1);
      b_get(r, i);
      total++;
      if (r !== 2'b10) begin bad++; $display("FAIL err_write_b got=%b want=10", r); end
      read_word(32'h8000_0300, d);
      total++;
      if (d !== 32'h1234_5678) begin bad++; $display("FAIL err_write_data got=%h want=12345678", d); end
      ar_send(32'h8000_0010, 4'h9, 8'd2, 2'b10, 3'd2);
      for (int k = 0; k < 3; k++) begin
         r_get(d, r, l, i);
         total++;
         if ({d, r, l, i} !== {32'h0, 2'b10, k == 2, 4'h9}) begin
            bad++; $display("FAIL err_read_beat%0d got=%h/%b/%b/%h want=0/10/%b/9", k, d, r, l, i, k == 2);
         end
      end
   endtask

   task automatic test_concurrency;
      logic [1:0] r; logic [3:0] i; logic [31:0] d; logic l;
      write_word(32'h8000_0400, 32'h0000_1111, 4'hF);
      aw_send(32'h8000_0400, 4'h2, 8'd0, 2'b01, 3'd2);
      ar_send(32'h8000_0400, 4'h2, 8'd0, 2'b01, 3'd2);
      wvalid = 1'b1; wdata = 32'h0000_2222; wstrb = 4'hF; wlast = 1'b1;
      @(posedge clock); #1; wvalid = 1'b0;
      r_get(d, r, l, i);
      total++;
      if (d !== 32'h0000_2222) begin bad++; $display("FAIL raw_next_edge got=%h want=00002222", d); end
      b_get(r, i);
      write_word(32'h8000_0404, 32'h0000_3333, 4'hF);
      aw_send(32'h8000_0404, 4'h2, 8'd0, 2'b01, 3'd2);
      ar_send(32'h8000_0404, 4'h2, 8'd0, 2'b01, 3'd2);
      @(posedge clock); #1;
      wvalid = 1'b1; wdata = 32'h0000_4444; wstrb = 4'hF; wlast = 1'b1;
      @(posedge clock); #1; wvalid = 1'b0;
      r_get(d, r, l, i);
      total++;
      if (d !== 32'h0000_3333) begin bad++; $display("FAIL raw_same_edge got=%h want=00003333", d); end
      b_get(r, i);
      read_word(32'h8000_0404, d);
      total++;
      if (d !== 32'h0000_4444) begin bad++; $display("FAIL raw_after got=%h want=00004444", d); end
   endtask

   task automatic test_reset_mid_read;
      logic [31:0] d;
      ar_send(32'h8000_0000, 4'h4, 8'd7, 2'b01, 3'd2);
      for (int n = 0; n < 10 && !rvalid; n++) begin @(posedge clock); #1; end
      rready = 1'b1; @(posedge clock); #1; rready = 1'b0;
      total++;
      if ({rvalid, rdata} !== {1'b1, 32'd2}) begin bad++; $display("FAIL mid_beat got=%b/%h want=1/2", rvalid, rdata); end
      reset = 1'b1;
      @(posedge clock); #1;
      total++;
      if ({rvalid, arready, rlast} !== 3'b000) begin bad++; $display("FAIL abort got=%b want=000", {rvalid, arready, rlast}); end
      reset = 1'b0;
      @(posedge clock); #1;
      total++;
      if ({arready, rvalid} !== 2'b10) begin bad++; $display("FAIL post_reset got=%b want=10", {arready, rvalid}); end
      read_word(32'h8000_0004, d);
      total++;
      if (d !== 32'd2) begin bad++; $display("FAIL mem_kept got=%h want=2", d); end
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      test_reset();
      test_single_read();
      test_incr_backpressure();
      test_strobe_write();
      test_wlast_mismatch();
      test_error_bursts();
      test_concurrency();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
